// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package cpu_pkg;

  localparam int INSTR_WIDTH = 32;
  localparam logic [INSTR_WIDTH-1:0] NOP_WORD = '0;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PAD,
    HOLD,
    DONE
  } loader_state_e;

endpackage

// File: rtl/load_hold_counter.sv
// Down-counter that strobes expired on the last of HOLD_CYCLES enabled cycles
// following a load.
module load_hold_counter #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CW = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   cnt <= '0;
    else if (load)               cnt <= CW'(HOLD_CYCLES - 1);
    else if (en && cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign expired = en && (cnt == '0);

endmodule

// File: rtl/instr_mem_loader.sv
// Streams program words into instruction memory, zero-fills the rest, then
// releases the CPU from reset a fixed number of cycles after the last write.
module instr_mem_loader
  import cpu_pkg::*;
#(
  parameter int NUM_WORDS   = 32,
  parameter int ADDR_STEP   = 4,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [INSTR_WIDTH-1:0]        in_word,
  input  logic                          in_last,
  output logic                          mem_we,
  output logic [31:0]                   mem_addr,
  output logic [INSTR_WIDTH-1:0]        mem_wdata,
  output logic                          cpu_reset,
  output logic                          done,
  output logic                          error,
  output logic [$clog2(NUM_WORDS):0]    word_count,
  output logic [31:0]                   checksum
);

  localparam int SW = $clog2(NUM_WORDS) + 1;
  localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_WORDS - 1);

  loader_state_e state, state_nx;

  logic [SW-1:0]          slot, slot_nx;
  logic [SW-1:0]          word_count_nx;
  logic [31:0]            checksum_nx;
  logic                   mem_we_nx;
  logic [31:0]            mem_addr_nx;
  logic [INSTR_WIDTH-1:0] mem_wdata_nx;
  logic                   cpu_reset_nx, done_nx, error_nx;
  logic                   hold_load, hold_expired, begin_load;
  logic [31:0]            slot_addr;

  assign in_ready  = (state == LOAD);
  assign slot_addr = 32'(slot) * 32'(ADDR_STEP);
  assign begin_load = start && (state == IDLE || state == DONE);

  load_hold_counter #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold (
    .clk     (clk),
    .reset   (reset),
    .load    (hold_load),
    .en      (state == HOLD),
    .expired (hold_expired)
  );

  always_comb begin
    state_nx      = state;
    slot_nx       = slot;
    word_count_nx = word_count;
    checksum_nx   = checksum;
    mem_we_nx     = 1'b0;
    mem_addr_nx   = mem_addr;
    mem_wdata_nx  = mem_wdata;
    cpu_reset_nx  = cpu_reset;
    done_nx       = done;
    error_nx      = error;
    hold_load     = 1'b0;

    if (begin_load) begin
      state_nx      = LOAD;
      slot_nx       = '0;
      word_count_nx = '0;
      checksum_nx   = '0;
      cpu_reset_nx  = 1'b1;
      done_nx       = 1'b0;
      error_nx      = 1'b0;
    end

    case (state)
      LOAD: begin
        if (in_valid) begin
          mem_we_nx     = 1'b1;
          mem_addr_nx   = slot_addr;
          mem_wdata_nx  = in_word;
          slot_nx       = slot + 1'b1;
          word_count_nx = word_count + 1'b1;
          checksum_nx   = checksum + in_word;
          // The final slot decides between a clean fit and an overflow.
          if (slot == LAST_SLOT) begin
            if (in_last) begin
              state_nx  = HOLD;
              hold_load = 1'b1;
            end else begin
              state_nx = DONE;
              error_nx = 1'b1;
            end
          end else if (in_last) begin
            state_nx = PAD;
          end
        end
      end
      PAD: begin
        mem_we_nx    = 1'b1;
        mem_addr_nx  = slot_addr;
        mem_wdata_nx = NOP_WORD;
        slot_nx      = slot + 1'b1;
        if (slot == LAST_SLOT) begin
          state_nx  = HOLD;
          hold_load = 1'b1;
        end
      end
      HOLD: begin
        if (hold_expired) begin
          state_nx     = DONE;
          cpu_reset_nx = 1'b0;
          done_nx      = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      slot       <= '0;
      word_count <= '0;
      checksum   <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_nx;
      slot       <= slot_nx;
      word_count <= word_count_nx;
      checksum   <= checksum_nx;
      mem_we     <= mem_we_nx;
      mem_addr   <= mem_addr_nx;
      mem_wdata  <= mem_wdata_nx;
      cpu_reset  <= cpu_reset_nx;
      done       <= done_nx;
      error      <= error_nx;
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader with an 8-word memory.
module tb_instr_mem_loader;

  localparam int NW = 8;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_last;
  logic [31:0] in_word;
  logic        in_ready, mem_we, cpu_reset, done, error;
  logic [31:0] mem_addr, mem_wdata, checksum;
  logic [3:0]  word_count;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_mem_loader #(.NUM_WORDS(NW), .ADDR_STEP(4), .HOLD_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_word    (in_word),
    .in_last    (in_last),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error),
    .word_count (word_count),
    .checksum   (checksum)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w, input logic last);
    in_valid = 1'b1;
    in_word  = w;
    in_last  = last;
    tick();
  endtask

  task automatic pulse_start();
    in_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20 && !done; i++) tick();
    chk("done_reached", {31'b0, done}, 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"},   {31'b0, in_ready},  32'd0);
    chk({tag, "_mem_we"},     {31'b0, mem_we},    32'd0);
    chk({tag, "_mem_addr"},   mem_addr,           32'd0);
    chk({tag, "_mem_wdata"},  mem_wdata,          32'd0);
    chk({tag, "_cpu_reset"},  {31'b0, cpu_reset}, 32'd1);
    chk({tag, "_done"},       {31'b0, done},      32'd0);
    chk({tag, "_error"},      {31'b0, error},     32'd0);
    chk({tag, "_word_count"}, {28'b0, word_count}, 32'd0);
    chk({tag, "_checksum"},   checksum,           32'd0);
  endtask

  initial begin
    logic [31:0] prog [3];
    logic [31:0] exp_sum;

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_word = '0;
    tick(); tick();
    chk_reset_vals("por");
    reset = 1'b0;
    tick();
    chk("idle_in_ready", {31'b0, in_ready}, 32'd0);

    // Short program followed by zero fill and a 4-cycle hold.
    prog[0] = 32'h8B020020; prog[1] = 32'hCB030041; prog[2] = 32'hF8000002;
    exp_sum = prog[0] + prog[1] + prog[2];
    pulse_start();
    chk("load_in_ready", {31'b0, in_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      send(prog[i], i == 2);
      chk("prog_we",    {31'b0, mem_we}, 32'd1);
      chk("prog_addr",  mem_addr, 32'(i * 4));
      chk("prog_wdata", mem_wdata, prog[i]);
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("pad_in_ready", {31'b0, in_ready}, 32'd0);
    for (int p = 3; p < NW; p++) begin
      tick();
      chk("pad_we",    {31'b0, mem_we}, 32'd1);
      chk("pad_addr",  mem_addr, 32'(p * 4));
      chk("pad_wdata", mem_wdata, 32'd0);
    end
    chk("short_count",    {28'b0, word_count}, 32'd3);
    chk("short_checksum", checksum, exp_sum);
    for (int h = 0; h < 3; h++) begin
      tick();
      chk("hold_cpu_reset", {31'b0, cpu_reset}, 32'd1);
      chk("hold_we",        {31'b0, mem_we},    32'd0);
    end
    tick();
    chk("release_cpu_reset", {31'b0, cpu_reset}, 32'd0);
    chk("release_done",      {31'b0, done},      32'd1);
    tick();
    chk("done_hold_cpu_reset", {31'b0, cpu_reset}, 32'd0);

    // Re-load from DONE with gaps in the stream.
    pulse_start();
    chk("reload_cpu_reset", {31'b0, cpu_reset}, 32'd1);
    chk("reload_done",      {31'b0, done},      32'd0);
    chk("reload_count",     {28'b0, word_count}, 32'd0);
    chk("reload_checksum",  checksum,           32'd0);
    send(32'hAAAA0001, 1'b0);
    chk("bp_w0_we",   {31'b0, mem_we}, 32'd1);
    chk("bp_w0_addr", mem_addr, 32'd0);
    chk("bp_w0_data", mem_wdata, 32'hAAAA0001);
    in_valid = 1'b0;
    tick();
    chk("bp_gap_we", {31'b0, mem_we}, 32'd0);
    send(32'hBBBB0002, 1'b1);
    chk("bp_w1_we",   {31'b0, mem_we}, 32'd1);
    chk("bp_w1_addr", mem_addr, 32'd4);
    chk("bp_w1_data", mem_wdata, 32'hBBBB0002);
    send(32'hCCCC0003, 1'b1);
    chk("bp_extra_addr", mem_addr, 32'd8);
    chk("bp_extra_data", mem_wdata, 32'd0);
    in_valid = 1'b0;
    wait_done();
    chk("bp_count",    {28'b0, word_count}, 32'd2);
    chk("bp_checksum", checksum, 32'h6665_0003);

    // Exact fit: no zero fill.
    pulse_start();
    exp_sum = '0;
    for (int i = 0; i < NW; i++) begin
      send(32'h1000_0000 + 32'(i), i == NW - 1);
      exp_sum += 32'h1000_0000 + 32'(i);
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("fit_last_addr", mem_addr, 32'd28);
    chk("fit_last_data", mem_wdata, 32'h1000_0007);
    chk("fit_in_ready",  {31'b0, in_ready}, 32'd0);
    tick();
    chk("fit_no_pad", {31'b0, mem_we}, 32'd0);
    wait_done();
    chk("fit_error",    {31'b0, error}, 32'd0);
    chk("fit_count",    {28'b0, word_count}, 32'd8);
    chk("fit_checksum", checksum, exp_sum);

    // Overflow: 8 words without last; a 9th word held valid stays unaccepted.
    pulse_start();
    for (int i = 0; i < NW; i++) send(32'h2000_0000 + 32'(i), 1'b0);
    chk("ovf_error",     {31'b0, error},     32'd1);
    chk("ovf_done",      {31'b0, done},      32'd0);
    chk("ovf_cpu_reset", {31'b0, cpu_reset}, 32'd1);
    chk("ovf_in_ready",  {31'b0, in_ready},  32'd0);
    in_word = 32'h2000_0008;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("ovf_no_write", {31'b0, mem_we}, 32'd0);
    end
    chk("ovf_count",     {28'b0, word_count}, 32'd8);
    chk("ovf_cpu_reset2", {31'b0, cpu_reset}, 32'd1);
    chk("ovf_done2",     {31'b0, done},      32'd0);

    // Reset mid-stream clears everything without waiting for a clock edge.
    pulse_start();
    chk("mid_clear_error", {31'b0, error}, 32'd0);
    for (int i = 0; i < 3; i++) send(32'h3000_0000 + 32'(i), 1'b0);
    chk("mid_count", {28'b0, word_count}, 32'd3);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("midrst");
    in_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk_reset_vals("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
